// File: rtl/viterbi_pkg.sv
// Shared types for the 4-state (K=3) Viterbi decoder: trellis state, traceback FSM
// states and the survivor predecessor selector.
package viterbi_pkg;

    typedef logic [1:0] st_t;

    localparam st_t ST_00 = 2'b00;
    localparam st_t ST_01 = 2'b01;
    localparam st_t ST_10 = 2'b10;
    localparam st_t ST_11 = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, STEP, DRAIN} tb_state_t;

    function automatic st_t sel_prv(input st_t cur, input st_t p00, input st_t p01,
                                    input st_t p10, input st_t p11);
        st_t p;
        case (cur)
            ST_00:   p = p00;
            ST_01:   p = p01;
            ST_10:   p = p10;
            default: p = p11;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/traceback_lifo.sv
// DEPTH x 1-bit LIFO used to turn newest-first traceback bits into forward order.
// dout always shows the most recently pushed bit still stored.
module traceback_lifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [SW-1:0]    sp;
    logic [SW-1:0]    top;

    assign top  = sp - 1'b1;
    assign dout = mem[top[IW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push) begin
            mem[sp[IW-1:0]] <= din;
            sp              <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/traceback.sv
// Viterbi survivor-memory traceback: walks DEPTH entries backwards from an end state.
// Optional macro TRACEBACK_REORDER_EN emits bits oldest-first through a LIFO.
module traceback
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    start_st,
    input  logic [AW-1:0] last_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    bck_prv_st_00,
    input  logic [1:0]    bck_prv_st_01,
    input  logic [1:0]    bck_prv_st_10,
    input  logic [1:0]    bck_prv_st_11,
    output logic          busy,
    output logic          dec_bit,
    output logic          dec_vld,
    output logic          dec_last,
    output logic          done
);
    localparam int            CW       = AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    tb_state_t     state;
    st_t           cur_st;
    st_t           prv;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rd_cnt;
    logic          consume;
    logic          final_step;

    // A read issued in RD returns data one cycle later, so it is consumed on the next RD visit.
    assign prv        = sel_prv(cur_st, bck_prv_st_00, bck_prv_st_01, bck_prv_st_10, bck_prv_st_11);
    assign consume    = (state == RD) && (cnt < rd_cnt);
    assign final_step = consume && (cnt == CNT_LAST);

`ifdef TRACEBACK_REORDER_EN
    logic lifo_dout;

    traceback_lifo #(.DEPTH(DEPTH)) u_lifo (
        .clk  (clk),
        .rst  (rst),
        .push (consume),
        .din  (cur_st[1]),
        .pop  (state == DRAIN),
        .dout (lifo_dout)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_st   <= ST_00;
            addr     <= '0;
            cnt      <= '0;
            rd_cnt   <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            dec_bit  <= 1'b0;
            dec_vld  <= 1'b0;
            dec_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            dec_vld  <= 1'b0;
            dec_last <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    rd_en <= 1'b0;
                    if (start) begin
                        cur_st <= start_st;
                        addr   <= last_addr;
                        cnt    <= '0;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= RD;
                    end
                end
                RD: begin
                    if (consume) begin
                        cur_st <= prv;
                        cnt    <= cnt + 1'b1;
`ifndef TRACEBACK_REORDER_EN
                        dec_bit <= cur_st[1];
                        dec_vld <= 1'b1;
`endif
                    end
                    if (rd_cnt != CNT_FULL) begin
                        rd_en   <= 1'b1;
                        rd_addr <= addr;
                        addr    <= (addr == '0) ? LAST_IDX : addr - 1'b1;
                        rd_cnt  <= rd_cnt + 1'b1;
                        state   <= STEP;
                    end
                    if (final_step) begin
`ifdef TRACEBACK_REORDER_EN
                        cnt   <= '0;
                        state <= DRAIN;
`else
                        dec_last <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
`endif
                    end
                end
                STEP: begin
                    rd_en <= 1'b0;
                    state <= RD;
                end
                DRAIN: begin
`ifdef TRACEBACK_REORDER_EN
                    dec_bit <= lifo_dout;
                    dec_vld <= 1'b1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        dec_last <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback.sv
// Directed self-checking bench for traceback; a registered survivor-memory model
// with 1-cycle read latency answers rd_en/rd_addr.
module tb_traceback;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NCYC  = 3 * DEPTH + 6;
`ifdef TRACEBACK_REORDER_EN
    localparam int EXP_FIRST = 2 * DEPTH + 2;
    localparam int EXP_LAST  = 3 * DEPTH + 1;
`else
    localparam int EXP_FIRST = 3;
    localparam int EXP_LAST  = 2 * DEPTH + 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    start_st = 2'b00;
    logic [AW-1:0] last_addr = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    bck_prv_st_00 = 2'b00;
    logic [1:0]    bck_prv_st_01 = 2'b00;
    logic [1:0]    bck_prv_st_10 = 2'b00;
    logic [1:0]    bck_prv_st_11 = 2'b00;
    logic          busy, dec_bit, dec_vld, dec_last, done;

    int errors = 0;
    int checks = 0;

    logic [1:0]    mem_prv [DEPTH][4];
    logic [15:0]   u_pat = 16'b0001_0111_0100_1101;  // u[t] for t=0..15: 1,0,1,1,0,0,1,0,1,1,1,0,1,0,0,0

    logic          got_bits [64];
    logic [AW-1:0] got_addr [64];
    int nbits, nrd, rd_first, vld_first, vld_last, last_cyc, done_cnt, done_cyc;
    logic busy_at1, busy_end;

    always #5 clk = ~clk;

    traceback #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_st(start_st), .last_addr(last_addr),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .bck_prv_st_00(bck_prv_st_00), .bck_prv_st_01(bck_prv_st_01),
        .bck_prv_st_10(bck_prv_st_10), .bck_prv_st_11(bck_prv_st_11),
        .busy(busy), .dec_bit(dec_bit), .dec_vld(dec_vld), .dec_last(dec_last), .done(done)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            bck_prv_st_00 <= mem_prv[rd_addr][0];
            bck_prv_st_01 <= mem_prv[rd_addr][1];
            bck_prv_st_10 <= mem_prv[rd_addr][2];
            bck_prv_st_11 <= mem_prv[rd_addr][3];
        end
    end

    task automatic fill_zero();
        for (int a = 0; a < DEPTH; a++)
            for (int s = 0; s < 4; s++) mem_prv[a][s] = 2'b00;
    endtask

    // Encode u_pat from state 00; step t lands at address last_addr+1+t (mod DEPTH).
    task automatic fill_pattern(input logic [AW-1:0] la);
        logic [1:0] prev, st;
        logic [AW-1:0] a;
        prev = 2'b00;
        for (int t = 0; t < DEPTH; t++) begin
            st = {u_pat[t], prev[1]};
            a  = la + AW'(1) + AW'(t);
            for (int s = 0; s < 4; s++) mem_prv[a][s] = (2'(s) == st) ? prev : ~prev;
            prev = st;
        end
    endtask

    task automatic run(input logic [1:0] sst, input logic [AW-1:0] la, input bit inject);
        nbits = 0; nrd = 0; rd_first = -1; vld_first = -1; vld_last = -1;
        last_cyc = -1; done_cnt = 0; done_cyc = -1; busy_at1 = 1'b0; busy_end = 1'b1;
        @(negedge clk);
        start = 1'b1; start_st = sst; last_addr = la;
        @(posedge clk); #1;
        start = 1'b0; start_st = ~sst; last_addr = ~la;
        for (int cyc = 1; cyc <= NCYC; cyc++) begin
            @(posedge clk); #1;
            if (rd_en) begin
                if (nrd < 64) got_addr[nrd] = rd_addr;
                if (rd_first < 0) rd_first = cyc;
                nrd++;
            end
            if (dec_vld) begin
                if (nbits < 64) got_bits[nbits] = dec_bit;
                if (vld_first < 0) vld_first = cyc;
                vld_last = cyc;
                nbits++;
            end
            if (dec_last) last_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (cyc == 1) busy_at1 = busy;
            if (cyc == NCYC) busy_end = busy;
            if (inject && cyc == 5) begin start = 1'b1; start_st = 2'b11; last_addr = 4'd7; end
            if (inject && cyc == 6) start = 1'b0;
        end
    endtask

    function automatic logic [15:0] pack_bits();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k] = got_bits[k];
        return v;
    endfunction

    function automatic logic [15:0] exp_pattern();
        logic [15:0] v;
        for (int k = 0; k < 16; k++) begin
`ifdef TRACEBACK_REORDER_EN
            v[k] = u_pat[k];
`else
            v[k] = u_pat[15-k];
`endif
        end
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, rd_addr, busy, dec_bit, dec_vld, dec_last, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_en=%b rd_addr=%0d busy=%b bit=%b vld=%b last=%b done=%b, want all 0",
                     rd_en, rd_addr, busy, dec_bit, dec_vld, dec_last, done);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: busy=%b rd_en=%b, want 0 0", busy, rd_en);
        end
    endtask

    task automatic test_all_zero();
        fill_zero();
        run(2'b00, 4'd15, 1'b0);
        checks++;
        if (nbits !== 16) begin errors++; $display("FAIL zero_count: got %0d bits, want 16", nbits); end
        checks++;
        if (pack_bits() !== 16'h0000) begin errors++; $display("FAIL zero_bits: got %h, want 0000", pack_bits()); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d, want 1", done_cnt); end
        checks++;
        if (last_cyc !== vld_last) begin errors++; $display("FAIL zero_last_on_16th: dec_last at %0d, last vld at %0d", last_cyc, vld_last); end
    endtask

    task automatic test_pattern();
        fill_pattern(4'd15);
        run(2'b00, 4'd15, 1'b0);
        checks++;
        if (nbits !== 16) begin errors++; $display("FAIL pattern_count: got %0d bits, want 16", nbits); end
        checks++;
        if (pack_bits() !== exp_pattern()) begin
            errors++; $display("FAIL pattern_bits: got %h, want %h", pack_bits(), exp_pattern());
        end
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] ea;
        int bad;
        fill_pattern(4'd3);
        run(2'b00, 4'd3, 1'b0);
        checks++;
        if (nrd !== DEPTH) begin errors++; $display("FAIL wrap_rd_en_cycles: got %0d, want %0d", nrd, DEPTH); end
        bad = 0;
        ea = 4'd3;
        for (int k = 0; k < DEPTH && k < nrd; k++) begin
            if (got_addr[k] !== ea && bad == 0) begin
                bad = 1;
                $display("FAIL wrap_addr[%0d]: got %0d, want %0d", k, got_addr[k], ea);
            end
            ea = ea - 1'b1;
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (pack_bits() !== exp_pattern()) begin
            errors++; $display("FAIL wrap_bits: got %h, want %h", pack_bits(), exp_pattern());
        end
    endtask

    task automatic test_timing();
        fill_pattern(4'd15);
        run(2'b00, 4'd15, 1'b0);
        checks++;
        if (rd_first !== 1) begin errors++; $display("FAIL timing_rd_en: first at %0d, want 1", rd_first); end
        checks++;
        if (vld_first !== EXP_FIRST) begin errors++; $display("FAIL timing_first_vld: at %0d, want %0d", vld_first, EXP_FIRST); end
        checks++;
        if (done_cyc !== EXP_LAST) begin errors++; $display("FAIL timing_done: at %0d, want %0d", done_cyc, EXP_LAST); end
        checks++;
        if (last_cyc !== EXP_LAST) begin errors++; $display("FAIL timing_dec_last: at %0d, want %0d", last_cyc, EXP_LAST); end
        checks++;
        if (busy_at1 !== 1'b1 || busy_end !== 1'b0) begin
            errors++; $display("FAIL timing_busy: cyc1=%b end=%b, want 1 0", busy_at1, busy_end);
        end
    endtask

    task automatic test_ignore_start();
        fill_pattern(4'd15);
        run(2'b00, 4'd15, 1'b1);
        checks++;
        if (pack_bits() !== exp_pattern() || nbits !== 16) begin
            errors++; $display("FAIL busy_start_bits: got %h (%0d bits), want %h", pack_bits(), nbits, exp_pattern());
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== EXP_LAST) begin
            errors++; $display("FAIL busy_start_done: count %0d at %0d, want 1 at %0d", done_cnt, done_cyc, EXP_LAST);
        end
        checks++;
        if (nrd !== DEPTH) begin errors++; $display("FAIL busy_start_reads: got %0d, want %0d", nrd, DEPTH); end
    endtask

    task automatic test_midrun_reset();
        int act;
        fill_pattern(4'd15);
        @(negedge clk);
        start = 1'b1; start_st = 2'b00; last_addr = 4'd15;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rd_en, rd_addr, busy, dec_bit, dec_vld, dec_last, done} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: rd_en=%b rd_addr=%0d busy=%b bit=%b vld=%b last=%b done=%b, want all 0",
                     rd_en, rd_addr, busy, dec_bit, dec_vld, dec_last, done);
        end
        rst = 1'b0;
        act = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk); #1;
            if (rd_en || busy || dec_vld || done) act++;
        end
        checks++;
        if (act !== 0) begin errors++; $display("FAIL midrun_reset_quiet: %0d active cycles, want 0", act); end
        run(2'b00, 4'd15, 1'b0);
        checks++;
        if (pack_bits() !== exp_pattern() || done_cyc !== EXP_LAST) begin
            errors++; $display("FAIL after_reset_run: bits %h done at %0d, want %h at %0d",
                               pack_bits(), done_cyc, exp_pattern(), EXP_LAST);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_pattern();
        test_addr_wrap();
        test_timing();
        test_ignore_start();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
